flag_buf: RTL and testbench

- Single-entry data holding register with a "data valid" flag.
- Sits between a byte producer (e.g. a UART receiver) and a consumer, such as a CPU/bus interface that polls the flag.
- The producer pulses set_flag to capture din and raise the flag. The consumer reads dout, then pulses clr_flag to acknowledge.

---
 rtl/flag_buf_if.sv | 30 +++
 rtl/flag_buf.sv | 37 +++
 tb/tb_flag_buf.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/flag_buf_if.sv
// Purpose: producer/consumer side of the single-entry flag buffer.
// Latency: none, this is wiring only.
// Backpressure: none; the consumer polls flag and acknowledges with clr_flag.
interface flag_buf_if #(
   parameter int W = 8
);
   logic         set_flag;
   logic         clr_flag;
   logic [W-1:0] din;
   logic         flag;
   logic [W-1:0] dout;

   // Producer/consumer side: drives requests and data, observes the buffer.
   modport master (
      output set_flag,
      output clr_flag,
      output din,
      input  flag,
      input  dout
   );

   // Buffer side: receives requests and data, presents registered state.
   modport slave (
      input  set_flag,
      input  clr_flag,
      input  din,
      output flag,
      output dout
   );
endinterface

// File: rtl/flag_buf.sv
// Purpose: single-entry data register with a "data valid" flag between a byte producer and a polling consumer.
// Latency: one clock from set_flag/clr_flag to flag/dout; both outputs come straight from registers.
// Backpressure: none; a set while full overwrites silently, a set on the same edge as a clear wins.
module flag_buf #(
   parameter int W = 8
) (
   input  logic       clk,
   input  logic       reset,
   flag_buf_if.slave  fb
);
   logic [W-1:0] buf_reg;
   logic         flag_reg;

   // Capture din on set; otherwise hold. A clear never touches the data so
   // the consumer can still read dout after acknowledging.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_reg <= '0;
      end else if (fb.set_flag) begin
         buf_reg <= fb.din;
      end
   end

   // Flag raised by set, dropped by clear; set takes priority when both occur.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_reg <= 1'b0;
      end else if (fb.set_flag) begin
         flag_reg <= 1'b1;
      end else if (fb.clr_flag) begin
         flag_reg <= 1'b0;
      end
   end

   assign fb.dout = buf_reg;
   assign fb.flag = flag_reg;
endmodule

// File: tb/tb_flag_buf.sv
// Purpose: self-checking bench for flag_buf against a load-history reference model.
// Latency: expects outputs one clock after the sampling edge, and immediately on reset.
// Backpressure: none to model; overwrite and set-over-clear priority are exercised.
module tb_flag_buf;
   localparam int W = 8;

   logic clk;
   logic reset;

   flag_buf_if #(.W(W)) bus ();

   flag_buf #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .fb    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit done     = 1'b0;

   // Reference model: the list of values loaded since the last reset, and how
   // many loads have arrived since the consumer last acknowledged.
   logic [W-1:0] loads[$];
   int           unacked;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model update: reset wipes history; each sampled edge records a load or an ack.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         loads.delete();
         unacked = 0;
      end else if (bus.set_flag) begin
         loads.push_back(bus.din);
         unacked = unacked + 1;
      end else if (bus.clr_flag) begin
         unacked = 0;
      end
   end

   function automatic logic [W-1:0] model_dout();
      if (loads.size() == 0) return '0;
      return loads[loads.size()-1];
   endfunction

   function automatic logic model_flag();
      return unacked > 0;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!done) begin
         check("model_flag", {{(W-1){1'b0}}, bus.flag}, {{(W-1){1'b0}}, model_flag()});
         check("model_dout", bus.dout, model_dout());
      end
   end

   // Apply inputs (called at a negedge), let one rising edge sample them,
   // return at the following negedge.
   task automatic cyc(input logic s, input logic c, input logic [W-1:0] d);
      bus.set_flag = s;
      bus.clr_flag = c;
      bus.din      = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_lit(input string name, input logic f, input logic [W-1:0] d);
      check({name, "_flag"}, {{(W-1){1'b0}}, bus.flag}, {{(W-1){1'b0}}, f});
      check({name, "_dout"}, bus.dout, d);
   endtask

   initial begin
      reset        = 1'b1;
      bus.set_flag = 1'b1;
      bus.clr_flag = 1'b0;
      bus.din      = 8'h01;
      #1;
      expect_lit("reset_initial", 1'b0, 8'h00);

      // Reset dominates a held set request.
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 8'h01);
         expect_lit("reset_hold", 1'b0, 8'h00);
      end
      reset = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 8'h01);
         expect_lit("idle", 1'b0, 8'h00);
      end

      cyc(1'b1, 1'b0, 8'h02);  expect_lit("load",        1'b1, 8'h02);
      cyc(1'b0, 1'b0, 8'h05);  expect_lit("load_hold",   1'b1, 8'h02);
      cyc(1'b0, 1'b1, 8'h03);  expect_lit("clear",       1'b0, 8'h02);
      cyc(1'b1, 1'b1, 8'h04);  expect_lit("set_and_clr", 1'b1, 8'h04);
      cyc(1'b1, 1'b0, 8'h11);  expect_lit("b2b_first",   1'b1, 8'h11);
      cyc(1'b1, 1'b0, 8'h22);  expect_lit("b2b_second",  1'b1, 8'h22);
      cyc(1'b0, 1'b1, 8'h00);  expect_lit("ack",         1'b0, 8'h22);
      cyc(1'b0, 1'b1, 8'h33);  expect_lit("clr_empty",   1'b0, 8'h22);

      // Held set: dout follows din one cycle behind.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 8'h40 + 8'(i));
         expect_lit("set_held", 1'b1, 8'h40 + 8'(i));
      end

      // Asynchronous reset mid-run must clear outputs before the next edge.
      cyc(1'b1, 1'b0, 8'hA5);  expect_lit("pre_reset", 1'b1, 8'hA5);
      bus.set_flag = 1'b0;
      #1 reset = 1'b1;
      #1 expect_lit("async_reset", 1'b0, 8'h00);
      @(negedge clk);
      cyc(1'b1, 1'b0, 8'h77);  expect_lit("reset_mid_hold", 1'b0, 8'h00);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 8'h77);  expect_lit("post_reset", 1'b0, 8'h00);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         logic s, c;
         logic [W-1:0] d;
         s = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 2) == 0);
         d = W'($urandom);
         bus.set_flag = s;
         bus.clr_flag = c;
         bus.din      = d;
         if ($urandom_range(0, 99) == 0) begin
            #2 reset = 1'b1;
            @(posedge clk);
            #2 reset = 1'b0;
            @(negedge clk);
         end else begin
            @(posedge clk);
            @(negedge clk);
         end
      end

      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
